// File: rtl/async_handshake_receiver.sv
`default_nettype none
// async_handshake_receiver: synchronizes a 4-phase request, acknowledges it and
// queues the bundled data in a DEPTH-entry FIFO.  Rev 1.0
module async_handshake_receiver #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       request_in,
  input  logic [3:0] data_in,
  output logic       ack_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [3:0] level,
  output logic [7:0] xfer_count
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_LVL = 4'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   req_s;
  logic                   push;
  logic                   pop;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [3:0]             mem [DEPTH];

  assign req_s     = sync[SYNC_STAGES-1];
  assign out_valid = (level != 4'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  // Push is decided from the registered level, so a full buffer never sees a write.
  assign push      = (state == IDLE) && req_s && (level < DEPTH_LVL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], request_in};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ack_out    <= 1'b0;
      xfer_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            state   <= ACK;
            ack_out <= 1'b1;
          end
        end
        ACK: begin
          if (!req_s) begin
            state      <= RELEASE;
            ack_out    <= 1'b0;
            xfer_count <= xfer_count + 8'd1;
          end
        end
        RELEASE: begin
          state   <= IDLE;
          ack_out <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ack_out <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 4'd0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + 4'd1;
        2'b01:   level <= level - 4'd1;
        default: level <= level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/async_handshake_receiver.md
ASYNC_HANDSHAKE_RECEIVER -- requirements
Module: async_handshake_receiver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output buffer entries; only 2, 4 or 8 are legal.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of flops in the request synchronizer; legal range 2 to 3.
REQ-003 SHALL have port clk, input, 1 bit, the single receiver clock.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port request_in, input, 1 bit, 4-phase request from the upstream asynchronous pipeline; asynchronous to clk.
REQ-006 SHALL have port data_in, input, 4 bits, bundled data; stable from request_in rise until ack_out rises.
REQ-007 SHALL have port ack_out, output, 1 bit, 4-phase acknowledge to the upstream pipeline.
REQ-008 SHALL have port out_valid, output, 1 bit, buffer head holds a word.
REQ-009 SHALL have port out_ready, input, 1 bit, consumer accepts the head word this cycle.
REQ-010 SHALL have port out_data, output, 4 bits, buffer head word.
REQ-011 SHALL have port level, output, 4 bits, current buffer occupancy, 0 to DEPTH.
REQ-012 SHALL have port xfer_count, output, 8 bits, count of completed upstream handshakes.

Function
REQ-013 SHALL pass request_in through SYNC_STAGES flops clocked by clk; all decisions SHALL use only the last stage, req_s.
REQ-014 SHALL implement a registered FSM with states IDLE, ACK and RELEASE.
REQ-015 In IDLE, ack_out SHALL be 0; on a cycle with req_s=1 and level<DEPTH, the FSM SHALL write data_in into the buffer, set ack_out=1 and go to ACK, all at the same edge.
REQ-016 In IDLE with req_s=1 and level=DEPTH, the FSM SHALL stay in IDLE with ack_out=0 and write nothing; this is back-pressure, and no data SHALL be lost.
REQ-017 In ACK, ack_out SHALL stay 1 until a cycle with req_s=0; at that edge the FSM SHALL go to RELEASE, set ack_out=0 and increment xfer_count.
REQ-018 In RELEASE, ack_out SHALL be 0; the FSM SHALL return to IDLE at the next edge unconditionally, giving one guaranteed low cycle of ack_out.
REQ-019 ack_out SHALL be driven directly from a flop, with no combinational path to any input.
REQ-020 Latency with SYNC_STAGES=2 and a non-full buffer: request_in rises before edge k, ack_out=1 and the word written after edge k+2, out_valid=1 after edge k+2.
REQ-021 The buffer SHALL be a first-in first-out buffer of DEPTH 4-bit entries with wrap-around read and write pointers.
REQ-022 out_data SHALL equal the head entry whenever out_valid=1; a pop SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-023 A push and a pop in the same cycle SHALL leave level unchanged; this includes level=DEPTH, where the pop frees the slot, but a push with level=DEPTH SHALL NOT be attempted (REQ-016 decides push from registered level).
REQ-024 out_ready=1 with out_valid=0 SHALL have no effect.
REQ-025 xfer_count SHALL wrap from 255 to 0.
REQ-026 out_valid SHALL equal (level != 0).

Reset
REQ-027 Asserting reset=0 SHALL, without waiting for clk, force: FSM state IDLE, ack_out=0, synchronizer flops 0, level=0, out_valid=0, out_data=0, pointers 0, xfer_count=0.
REQ-028 Reset during ACK or RELEASE SHALL drop ack_out to 0 immediately; any partial handshake is abandoned, and the upstream pipeline is reset by the same reset net.
REQ-029 After reset deasserts, the first edge SHALL behave as IDLE with req_s sampled from 0.

Verification
REQ-030 Single word: data_in=4'hA, request_in rises, out_ready=0 -> ack_out=1 two to three cycles later, out_data=4'hA, out_valid=1, level=1; drop request_in -> ack_out=0 within three cycles, xfer_count=1.
REQ-031 Fill and back-pressure: send 4'h1..4'h5, out_ready=0 -> four handshakes complete, level=4; the fifth request_in stays high with ack_out=0; out_ready=1 for one cycle -> 4'h1 popped, then 4'h5 acknowledged, level=4.
REQ-032 Drain order: after REQ-031, out_ready=1 continuously -> out_data sequence 4'h2,4'h3,4'h4,4'h5, then out_valid=0, level=0.
REQ-033 Simultaneous push and pop: level=2, new word captured on the same cycle as a pop -> level stays 2 and order is preserved.
REQ-034 Reset mid-handshake: reset=0 while ack_out=1 -> ack_out=0 and level=0 before the next clk edge; after release, request_in low then high with data 4'h7 -> normal capture.
REQ-035 Wrap: 256 handshakes with out_ready=1 -> xfer_count=0 and the buffer pointers wrap correctly, with the data sequence intact.
